game_flow_controller: RTL and testbench

Tick-aligned game-flow FSM that closes the loop around the lava wall controller. It consumes the lava wall's `hit_lava_wall` plus hazard and goal flags, and tracks the player's best forward progress as a score. It produces the `any_input_level`, `freeze` and `speed_boost_pulse` signals that the lava wall controller samples. It sits between the input/collision logic and the lava wall controller, level loader and HUD.

---
 rtl/game_flow_controller.sv | 162 ++++++++++++++++
 tb/tb_game_flow_controller.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/game_flow_controller.sv
// Game-flow FSM around the lava wall: best-progress score, boost and restart pulses, freeze.
// Buttons reach any_input_level in 3 clk; all else updates on game_tick (1 clk); no backpressure.
module game_flow_controller #(
    parameter int BOOST_STEP     = 100,
    parameter int MAX_BOOSTS     = 7,
    parameter int END_HOLD_TICKS = 180
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        game_tick,
    input  logic [3:0]  btn,
    input  logic        hit_lava_wall,
    input  logic        hit_hazard,
    input  logic        goal_reached,
    input  logic [9:0]  player_x,
    output logic        any_input_level,
    output logic        freeze,
    output logic        speed_boost_pulse,
    output logic        restart_pulse,
    output logic [1:0]  game_state,
    output logic [15:0] score
);
    localparam int BCW_RAW = $clog2(MAX_BOOSTS + 1);
    localparam int BCW     = (BCW_RAW < 3) ? 3 : BCW_RAW;
    localparam int HCW_RAW = $clog2(END_HOLD_TICKS + 1);
    localparam int HCW     = (HCW_RAW < 1) ? 1 : HCW_RAW;

    localparam logic [16:0]    STEP17    = 17'(BOOST_STEP);
    localparam logic [BCW-1:0] BOOST_MAX = BCW'(MAX_BOOSTS);
    localparam logic [BCW-1:0] BOOST_ONE = BCW'(1);
    localparam logic [HCW-1:0] HOLD_MAX  = HCW'(END_HOLD_TICKS);
    localparam logic [HCW-1:0] HOLD_ONE  = HCW'(1);

    typedef enum logic [1:0] {
        ST_READY = 2'b00,
        ST_PLAY  = 2'b01,
        ST_WIN   = 2'b10,
        ST_OVER  = 2'b11
    } state_t;

    state_t state_q, state_d;

    logic [3:0]     btn_meta, btn_sync;
    logic [9:0]     best_x_q, best_x_d;
    logic [15:0]    score_q, score_d;
    logic [16:0]    next_boost_q, next_boost_d;
    logic [BCW-1:0] boost_cnt_q, boost_cnt_d;
    logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
    logic           boost_q, boost_d;
    logic           restart_q, restart_d;
    logic           do_restart;
    logic [16:0]    score_sum;

    // Buttons are asynchronous: two flops, then a registered OR.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_meta        <= '0;
            btn_sync        <= '0;
            any_input_level <= 1'b0;
        end else begin
            btn_meta        <= btn;
            btn_sync        <= btn_meta;
            any_input_level <= |btn_sync;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_READY;
        end else if (game_tick) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_READY: if (any_input_level) state_d = ST_PLAY;
            ST_PLAY: begin
                if (hit_lava_wall || hit_hazard) state_d = ST_OVER;
                else if (goal_reached)           state_d = ST_WIN;
            end
            default:  if (do_restart) state_d = ST_READY;
        endcase
    end

    always_comb begin
        freeze     = (state_q == ST_WIN) || (state_q == ST_OVER);
        game_state = state_q;
    end

    // Only evaluated when player_x > best_x, so the 10-bit difference is positive.
    assign score_sum = {1'b0, score_q} + {7'd0, player_x - best_x_q};

    always_comb begin
        best_x_d     = best_x_q;
        score_d      = score_q;
        next_boost_d = next_boost_q;
        boost_cnt_d  = boost_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        boost_d      = 1'b0;
        restart_d    = 1'b0;
        do_restart   = 1'b0;
        case (state_q)
            ST_READY: begin
                if (any_input_level) best_x_d = player_x;
            end
            ST_PLAY: begin
                if (player_x > best_x_q) begin
                    score_d  = score_sum[16] ? 16'hFFFF : score_sum[15:0];
                    best_x_d = player_x;
                end
                // One threshold per tick; a big jump drains over consecutive ticks.
                if (({1'b0, score_d} >= next_boost_q) && (boost_cnt_q < BOOST_MAX)) begin
                    boost_d      = 1'b1;
                    boost_cnt_d  = boost_cnt_q + BOOST_ONE;
                    next_boost_d = next_boost_q + STEP17;
                end
            end
            default: begin
                if (hold_cnt_q >= HOLD_MAX) begin
                    if (any_input_level) begin
                        do_restart   = 1'b1;
                        restart_d    = 1'b1;
                        score_d      = '0;
                        best_x_d     = '0;
                        hold_cnt_d   = '0;
                        boost_cnt_d  = '0;
                        next_boost_d = STEP17;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_ONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            best_x_q     <= '0;
            score_q      <= '0;
            next_boost_q <= STEP17;
            boost_cnt_q  <= '0;
            hold_cnt_q   <= '0;
            boost_q      <= 1'b0;
            restart_q    <= 1'b0;
        end else if (game_tick) begin
            best_x_q     <= best_x_d;
            score_q      <= score_d;
            next_boost_q <= next_boost_d;
            boost_cnt_q  <= boost_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            boost_q      <= boost_d;
            restart_q    <= restart_d;
        end
    end

    assign speed_boost_pulse = boost_q;
    assign restart_pulse     = restart_q;
    assign score             = score_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// Bench for game_flow_controller: rule-level reference model feeds an expectation queue,
// a monitor pops and compares after every tick edge.
module tb_game_flow_controller;
    localparam int STEP  = 100;
    localparam int MAXB  = 7;
    localparam int HOLD  = 180;
    localparam int READY = 0, PLAY = 1, WIN = 2, OVER = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        game_tick = 1'b0;
    logic [3:0]  btn = 4'd0;
    logic        lava = 1'b0, haz = 1'b0, goal = 1'b0;
    logic [9:0]  px = 10'd0;
    logic        any_input_level, freeze, speed_boost_pulse, restart_pulse;
    logic [1:0]  game_state;
    logic [15:0] score;

    game_flow_controller #(
        .BOOST_STEP(STEP), .MAX_BOOSTS(MAXB), .END_HOLD_TICKS(HOLD)
    ) dut (
        .clk(clk), .rst(rst), .game_tick(game_tick), .btn(btn),
        .hit_lava_wall(lava), .hit_hazard(haz), .goal_reached(goal), .player_x(px),
        .any_input_level(any_input_level), .freeze(freeze),
        .speed_boost_pulse(speed_boost_pulse), .restart_pulse(restart_pulse),
        .game_state(game_state), .score(score)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st;
        int score;
        bit pulse;
        bit restart;
        bit frz;
        bit ail;
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad = 0;
    int obs_pulses = 0;

    int m_st, m_score, m_best, m_boosts, m_hold;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = READY; m_score = 0; m_best = 0; m_boosts = 0; m_hold = 0;
    endtask

    // Drive inputs, let them settle through the synchronizer, then issue one tick.
    task automatic issue(input logic [3:0] b, input logic l, input logic h,
                         input logic g, input logic [9:0] p);
        exp_t e;
        bit   ail;
        bit   pl;
        bit   rp;
        int   pi;
        @(negedge clk);
        btn = b; lava = l; haz = h; goal = g; px = p;
        repeat (3) @(negedge clk);
        ail = |b; pl = 0; rp = 0; pi = int'(p);
        if (m_st == READY) begin
            if (ail) begin m_st = PLAY; m_best = pi; end
        end else if (m_st == PLAY) begin
            if (pi > m_best) begin
                m_score = m_score + (pi - m_best);
                if (m_score > 65535) m_score = 65535;
                m_best = pi;
            end
            if (m_boosts < MAXB && m_score >= STEP * (m_boosts + 1)) begin
                pl = 1; m_boosts++;
            end
            if (l || h) m_st = OVER;
            else if (g) m_st = WIN;
        end else begin
            if (m_hold >= HOLD && ail) begin
                rp = 1; m_st = READY; m_score = 0; m_best = 0; m_boosts = 0; m_hold = 0;
            end else if (m_hold < HOLD) begin
                m_hold++;
            end
        end
        e.st = m_st; e.score = m_score; e.pulse = pl; e.restart = rp;
        e.frz = (m_st == WIN || m_st == OVER); e.ail = ail;
        exp_q.push_back(e);
        game_tick = 1'b1;
        @(negedge clk);
        game_tick = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_state"},   int'(game_state), 0);
        chk({tag, "_score"},   int'(score), 0);
        chk({tag, "_freeze"},  int'(freeze), 0);
        chk({tag, "_boost"},   int'(speed_boost_pulse), 0);
        chk({tag, "_restart"}, int'(restart_pulse), 0);
    endtask

    // Monitor: every tick edge out of reset must match the next queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (rst && game_tick) begin
                #1;
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_tick: no expectation queued at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("game_state", int'(game_state), e.st);
                    chk("score", int'(score), e.score);
                    chk("speed_boost_pulse", int'(speed_boost_pulse), int'(e.pulse));
                    chk("restart_pulse", int'(restart_pulse), int'(e.restart));
                    chk("freeze", int'(freeze), int'(e.frz));
                    chk("any_input_level", int'(any_input_level), int'(e.ail));
                    if (speed_boost_pulse) obs_pulses++;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int x;
        logic [9:0] rp;
        model_reset();

        // Reset held with random activity, including ticks.
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            btn = 4'($urandom); px = 10'($urandom); lava = 1'($urandom);
            haz = 1'($urandom); goal = 1'($urandom); game_tick = 1'($urandom);
        end
        @(posedge clk); #1;
        chk_idle("in_reset");
        chk("in_reset_ail", int'(any_input_level), 0);
        @(negedge clk);
        btn = 4'd0; lava = 0; haz = 0; goal = 0; px = 10'd0; game_tick = 0;
        rst = 1'b1;
        repeat (6) @(negedge clk);
        chk_idle("post_reset");
        chk("post_reset_ail", int'(any_input_level), 0);

        // Start, big forward jump, two boosts on consecutive ticks.
        issue(4'b0001, 0, 0, 0, 10'd0);
        base = obs_pulses;
        issue(4'b0000, 0, 0, 0, 10'd250);
        issue(4'b0000, 0, 0, 0, 10'd250);
        issue(4'b0000, 0, 0, 0, 10'd250);
        chk("two_boosts", obs_pulses - base, 2);
        issue(4'b0000, 0, 0, 0, 10'd200);
        issue(4'b0000, 0, 0, 0, 10'd260);

        // Lava beats goal on the same tick; then hold buttons through the hold window.
        issue(4'b0000, 1, 0, 1, 10'd270);
        repeat (HOLD) issue(4'b0001, 0, 0, 0, 10'd270);
        issue(4'b0001, 0, 0, 0, 10'd270);
        issue(4'b0000, 0, 0, 0, 10'd0);

        // Fresh run ending in WIN, restart with a different button.
        issue(4'b0100, 0, 0, 0, 10'd5);
        issue(4'b0000, 0, 0, 1, 10'd40);
        repeat (HOLD) issue(4'b0000, 0, 0, 0, 10'd40);
        issue(4'b0010, 0, 0, 0, 10'd40);

        // Ramp to 1000: exactly MAXB boosts.
        base = obs_pulses;
        issue(4'b1000, 0, 0, 0, 10'd0);
        x = 0;
        while (x < 1000) begin
            x = x + int'($urandom_range(40, 120));
            if (x > 1000) x = 1000;
            issue(4'b0000, 0, 0, 0, 10'(x));
        end
        repeat (10) issue(4'b0000, 0, 0, 0, 10'd1000);
        chk("boost_cap", obs_pulses - base, MAXB);

        // Async reset between ticks mid-PLAY.
        @(negedge clk); #2;
        rst = 1'b0;
        #1;
        chk_idle("async_reset_play");
        @(negedge clk); rst = 1'b1; model_reset();

        // Async reset with a boost pulse in flight.
        issue(4'b0001, 0, 0, 0, 10'd0);
        issue(4'b0000, 0, 0, 0, 10'd350);
        @(negedge clk); #2;
        rst = 1'b0;
        #1;
        chk_idle("async_reset_pulse");
        @(negedge clk); rst = 1'b1; model_reset();

        // Randomized play.
        rp = 10'd0;
        repeat (350) begin
            if ($urandom_range(0, 3) == 0) rp = 10'($urandom_range(0, 1023));
            else if (int'(rp) + 60 < 1023) rp = rp + 10'($urandom_range(0, 60));
            issue(($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0,
                  $urandom_range(0, 49) == 0, $urandom_range(0, 59) == 0,
                  $urandom_range(0, 39) == 0, rp);
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
